ac_rld: RTL and testbench

//  AC run-length decoder: the inverse of ac_rle. Consumes {zero_len,amplitude}

---
 rtl/ac_rld.sv | 142 ++++++++++++++
 tb/tb_ac_rld.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_rld.sv
`timescale 1ns/1ps
// AC run-length decoder: expands {zero_len, amp} symbols into the 63 AC
// coefficients of one 8x8 block through a one-entry registered output stage.
module ac_rld #(
   parameter int unsigned RLD_IN_WIDTH  = 20,
   parameter int unsigned RLD_OUT_WIDTH = 16,
   parameter int unsigned AC_NUM        = 63
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     sym_valid_i,
   input  logic [RLD_IN_WIDTH-1:0]  sym_data_i,
   output logic                     sym_ready_o,
   output logic                     coef_valid_o,
   output logic [RLD_OUT_WIDTH-1:0] coef_data_o,
   output logic [5:0]               coef_idx_o,
   output logic                     coef_last_o,
   input  logic                     coef_ready_i,
   output logic                     blk_done_o,
   output logic                     err_o
);

   localparam int unsigned RUN_W = RLD_IN_WIDTH - RLD_OUT_WIDTH;
   localparam int unsigned IDX_W = 6;
   localparam int unsigned SUM_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(AC_NUM);

   typedef enum logic [1:0] {S_WAIT, S_RUN, S_FILL} state_t;

   state_t                   state;
   logic [IDX_W-1:0]         load_idx;
   logic [RUN_W-1:0]         run_cnt;
   logic [RLD_OUT_WIDTH-1:0] amp_q;

   logic                     adv;
   logic                     sym_acc;
   logic                     is_eob;
   logic                     overrun;
   logic                     at_last;
   logic [RUN_W-1:0]         zero_len;
   logic [RLD_OUT_WIDTH-1:0] amp_in;
   logic                     ld_en;
   logic [RLD_OUT_WIDTH-1:0] ld_data;

   assign zero_len    = sym_data_i[RLD_IN_WIDTH-1:RLD_OUT_WIDTH];
   assign amp_in      = sym_data_i[RLD_OUT_WIDTH-1:0];
   assign is_eob      = (sym_data_i == '0);
   assign adv         = !coef_valid_o || coef_ready_i;
   assign sym_ready_o = !rst_i && (state == S_WAIT) && adv;
   assign sym_acc     = sym_valid_i && sym_ready_o;
   assign at_last     = (load_idx == IDX_LAST);
   // load_idx is the index the next loaded coefficient will carry
   assign overrun     = (SUM_W'(load_idx) + SUM_W'(zero_len)) > SUM_W'(AC_NUM);

   // Which value (if any) enters the output register on the next advance
   always_comb begin
      ld_en   = 1'b0;
      ld_data = '0;
      case (state)
         S_WAIT: begin
            if (sym_acc && !is_eob) begin
               ld_en   = 1'b1;
               ld_data = (overrun || zero_len != '0) ? '0 : amp_in;
            end
         end
         S_RUN: begin
            ld_en   = 1'b1;
            ld_data = (run_cnt == '0) ? amp_q : '0;
         end
         S_FILL: begin
            ld_en   = 1'b1;
         end
         default: begin
            ld_en   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_WAIT;
         load_idx     <= IDX_FIRST;
         run_cnt      <= '0;
         amp_q        <= '0;
         coef_valid_o <= 1'b0;
         coef_data_o  <= '0;
         coef_idx_o   <= '0;
         coef_last_o  <= 1'b0;
         blk_done_o   <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         blk_done_o <= coef_valid_o && coef_ready_i && coef_last_o;

         if (adv) begin
            coef_valid_o <= ld_en;
            if (ld_en) begin
               coef_data_o <= ld_data;
               coef_idx_o  <= load_idx;
               coef_last_o <= at_last;
               load_idx    <= at_last ? IDX_FIRST : load_idx + IDX_W'(1);
            end
         end

         // Loading index 63 always closes the block and drops any pending amp
         case (state)
            S_WAIT: begin
               if (sym_acc) begin
                  if (is_eob) begin
                     state <= S_FILL;
                  end else if (overrun) begin
                     err_o <= 1'b1;
                     state <= at_last ? S_WAIT : S_FILL;
                  end else if (zero_len != '0) begin
                     run_cnt <= zero_len - RUN_W'(1);
                     amp_q   <= amp_in;
                     state   <= at_last ? S_WAIT : S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (adv) begin
                  if (run_cnt == '0 || at_last) begin
                     state <= S_WAIT;
                  end else begin
                     run_cnt <= run_cnt - RUN_W'(1);
                  end
               end
            end
            S_FILL: begin
               if (adv && at_last) begin
                  state <= S_WAIT;
               end
            end
            default: begin
               state <= S_WAIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ac_rld.sv
`timescale 1ns/1ps
// Directed bench for ac_rld: block contents, handshake protocol, overrun and reset.
module tb_ac_rld;

   logic        clk = 1'b0;
   logic        rst;
   logic        sym_valid;
   logic [19:0] sym_data;
   logic        sym_ready;
   logic        coef_valid;
   logic [15:0] coef_data;
   logic [5:0]  coef_idx;
   logic        coef_last;
   logic        coef_ready;
   logic        blk_done;
   logic        err;

   int checks = 0;
   int errors = 0;

   logic [19:0] sym_q[$];
   int          got_idx[$];
   logic [15:0] got_data[$];
   logic        got_last[$];
   logic [15:0] exp_blk[1:63];

   int          hs_cnt;
   int          end_abs;
   int          done_cnt;
   int          viol;
   bit          prev_hs_last;
   bit          prev_stall;
   logic [15:0] prev_data;
   logic [5:0]  prev_idx;
   bit          pat[5];

   ac_rld dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .sym_valid_i (sym_valid),
      .sym_data_i  (sym_data),
      .sym_ready_o (sym_ready),
      .coef_valid_o(coef_valid),
      .coef_data_o (coef_data),
      .coef_idx_o  (coef_idx),
      .coef_last_o (coef_last),
      .coef_ready_i(coef_ready),
      .blk_done_o  (blk_done),
      .err_o       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic new_scn();
      sym_q.delete();
      got_idx.delete();
      got_data.delete();
      got_last.delete();
      hs_cnt   = 0;
      end_abs  = 0;
      done_cnt = 0;
      viol     = 0;
   endtask

   // One clock: drive after the edge, sample and check protocol at the negedge
   task automatic cycle(input bit use_sym, input bit rdy);
      int loaded;
      int pos;
      int r;
      int eidx;
      bit hs;
      @(posedge clk);
      #1;
      sym_valid  = use_sym && (sym_q.size() > 0);
      sym_data   = sym_valid ? sym_q[0] : 20'h0;
      coef_ready = rdy;
      @(negedge clk);
      if (blk_done !== prev_hs_last) viol++;
      if (prev_stall && (!coef_valid || coef_data !== prev_data || coef_idx !== prev_idx)) viol++;
      if (coef_valid && (coef_last !== (coef_idx == 6'd63))) viol++;
      loaded = hs_cnt + int'(coef_valid);
      if (sym_ready !== ((loaded >= end_abs) && (!coef_valid || coef_ready))) viol++;
      hs = coef_valid && coef_ready;
      if (sym_valid && sym_ready) begin
         pos = loaded % 63;
         r   = int'(sym_q[0][19:16]);
         if (sym_q[0] == 20'h0) eidx = 63;
         else eidx = (pos + 1 + r > 63) ? 63 : pos + 1 + r;
         end_abs = loaded - pos + eidx;
         void'(sym_q.pop_front());
      end
      if (hs) begin
         got_idx.push_back(int'(coef_idx));
         got_data.push_back(coef_data);
         got_last.push_back(coef_last);
         hs_cnt++;
      end
      if (blk_done) done_cnt++;
      prev_hs_last = hs && coef_last;
      prev_stall   = coef_valid && !coef_ready;
      prev_data    = coef_data;
      prev_idx     = coef_idx;
   endtask

   task automatic run(input int target, input bit stall);
      int cyc = 0;
      while (hs_cnt < target && cyc < 1000) begin
         cycle(1'b1, stall ? pat[cyc % 5] : 1'b1);
         cyc++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
   endtask

   task automatic zero_exp();
      for (int i = 1; i <= 63; i++) exp_blk[i] = 16'h0;
   endtask

   task automatic load_s2();
      sym_q = '{20'h00007, 20'h3FFFA, 20'h0FFFE, 20'h2FFF7, 20'hF0000, 20'h30008, 20'h00000};
      zero_exp();
      exp_blk[1]  = 16'h0007;
      exp_blk[5]  = 16'hFFFA;
      exp_blk[6]  = 16'hFFFE;
      exp_blk[9]  = 16'hFFF7;
      exp_blk[29] = 16'h0008;
   endtask

   task automatic chk_blk(input string tag, input int off);
      logic [31:0] obs;
      int k;
      for (int i = 1; i <= 63; i++) begin
         k = off + i - 1;
         if (k < got_idx.size()) obs = {9'b0, got_last[k], 6'(got_idx[k]), got_data[k]};
         else obs = 32'hFFFF_FFFF;
         chk($sformatf("%s_i%0d", tag, i), obs, {9'b0, (i == 63), 6'(i), exp_blk[i]});
      end
   endtask

   task automatic finish_scn(input string tag, input int n_hs, input int n_done, input bit err_exp);
      idle(4);
      chk({tag, "_cnt"}, hs_cnt, n_hs);
      chk({tag, "_done"}, done_cnt, n_done);
      chk({tag, "_proto"}, viol, 0);
      chk({tag, "_err"}, 32'(err), 32'(err_exp));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      pat        = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      rst        = 1'b1;
      sym_valid  = 1'b0;
      sym_data   = 20'h0;
      coef_ready = 1'b0;
      prev_hs_last = 1'b0;
      prev_stall   = 1'b0;
      prev_data    = 16'h0;
      prev_idx     = 6'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", 32'({sym_ready, coef_valid, coef_data, coef_idx, coef_last, blk_done, err}), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // EOB only
      new_scn();
      sym_q = '{20'h00000};
      zero_exp();
      run(63, 1'b0);
      finish_scn("s1", 63, 1, 1'b0);
      chk_blk("s1", 0);

      // Mixed runs, ZRL and EOB at full rate
      new_scn();
      load_s2();
      run(63, 1'b0);
      finish_scn("s2", 63, 1, 1'b0);
      chk_blk("s2", 0);

      // Same stream under downstream back-pressure
      new_scn();
      load_s2();
      run(63, 1'b1);
      finish_scn("s3", 63, 1, 1'b0);
      chk_blk("s3", 0);

      // 63 literal symbols with no EOB, then an EOB block
      new_scn();
      for (int k = 1; k <= 63; k++) sym_q.push_back(20'(k));
      sym_q.push_back(20'h00000);
      run(126, 1'b0);
      finish_scn("s4", 126, 2, 1'b0);
      for (int k = 1; k <= 63; k++) exp_blk[k] = 16'(k);
      chk_blk("s4a", 0);
      zero_exp();
      chk_blk("s4b", 63);

      // Run overrun at index 60
      new_scn();
      for (int k = 1; k <= 59; k++) sym_q.push_back(20'(k));
      sym_q.push_back(20'h50003);
      run(63, 1'b0);
      finish_scn("s5", 63, 1, 1'b1);
      zero_exp();
      for (int k = 1; k <= 59; k++) exp_blk[k] = 16'(k);
      chk_blk("s5", 0);
      new_scn();
      sym_q = '{20'h00000};
      zero_exp();
      run(63, 1'b0);
      finish_scn("s5b", 63, 1, 1'b1);
      chk_blk("s5b", 0);

      // Reset in the middle of a block
      new_scn();
      load_s2();
      run(19, 1'b0);
      chk("s6a_proto", viol, 0);
      chk("s6a_d5", 32'(got_data[4]), 32'h0000FFFA);
      @(posedge clk);
      #1;
      rst        = 1'b1;
      sym_valid  = 1'b0;
      coef_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("s6_rst_out", 32'({sym_ready, coef_valid, coef_data, coef_idx, coef_last, blk_done, err}), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      prev_hs_last = 1'b0;
      prev_stall   = 1'b0;
      new_scn();
      sym_q = '{20'h00000};
      zero_exp();
      run(63, 1'b0);
      finish_scn("s6", 63, 1, 1'b0);
      chk_blk("s6", 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
